// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, 100 MHz timing defaults and width helper for the button pulse generator
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 20000000;

    // Smallest width w with 2**w >= n, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - raw button synchronizer plus stable-count debouncer
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic btn_raw_i,
    output logic level_o,
    output logic level_next_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    assign sync   = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced button to increment pulses; BTN_AUTOREPEAT_EN adds hold auto-repeat
module button_pulse_gen
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic CLK100MHZ,
    input  logic Reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic pulse,
    output logic repeat_active
);

    localparam bit PARAMS_OK = (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 1) &&
                               (HOLD_CYCLES >= 2) && (REPEAT_CYCLES >= 2);

    if (!PARAMS_OK) begin : g_param_check
        $error("button_pulse_gen: illegal timing parameters");
    end

    logic       level_q;
    logic       level_next;
    logic       level_rise;
    btn_state_e state_q;
    btn_state_e state_d;
    logic       pulse_q;
    logic       pulse_d;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i        (CLK100MHZ),
        .resetn_i     (Reset_n),
        .btn_raw_i    (btn_raw),
        .level_o      (level_q),
        .level_next_o (level_next)
    );

    // The FSM reacts to the level being registered this edge so the first pulse lines up with btn_level.
    assign level_rise = level_next && !level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W   = cnt_width(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             repeat_q;
    logic             repeat_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pulse_d  = 1'b0;
        repeat_d = repeat_q;
        case (state_q)
            ST_IDLE: begin
                if (level_rise) begin
                    pulse_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                // Release wins over a coinciding hold expiry.
                if (!level_next) begin
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                    repeat_d = 1'b0;
                end else if (timer_q == HOLD_LAST) begin
                    pulse_d  = 1'b1;
                    timer_d  = '0;
                    repeat_d = 1'b1;
                    state_d  = ST_REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!level_next) begin
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                    repeat_d = 1'b0;
                end else if (timer_q == REPEAT_LAST) begin
                    pulse_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                timer_d  = '0;
                repeat_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            pulse_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pulse_q  <= pulse_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_active = repeat_q;
`else
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_rise) begin
                    pulse_d = 1'b1;
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (!level_next) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign repeat_active = 1'b0;
`endif

    assign btn_level = level_q;
    assign pulse     = pulse_q;

endmodule
